// File: rtl/wb_gpio_irq_bridge.sv
// Wishbone-classic GPIO slave: OUT/OEB/IN registers for up to 64 pads, 2-flop input sync,
// per-pin rise/fall edge capture into sticky W1C status, and N_IRQ registered interrupt lines.
module wb_gpio_irq_bridge #(
  parameter int unsigned N_IO      = 38,
  parameter int unsigned N_IRQ     = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] ID_VALUE  = 32'h0004_F740
) (
  input  logic              wb_clock_i,
  input  logic              wb_reset_i,
  input  logic              wb_cyc_i,
  input  logic              wb_strobe_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_addr_i,
  input  logic [31:0]       wb_data_i,
  output logic [31:0]       wb_data_o,
  output logic              wb_ack_o,
  input  logic [N_IO-1:0]   io_in,
  output logic [N_IO-1:0]   io_out,
  output logic [N_IO-1:0]   io_oeb,
  output logic [N_IRQ-1:0]  irq
);

  // Registers are kept 64 bits wide; bits at or above N_IO are held at zero by this mask.
  localparam logic [63:0] PIN_MASK = (N_IO >= 64) ? '1 : ((64'd1 << N_IO) - 64'd1);

  logic [63:0] out_r, oeb_r, rise_en_r, fall_en_r, stat_r;
  logic [63:0] s1, s2, prev;
  logic [63:0] out_n, oeb_n, rise_en_n, fall_en_n, stat_n, w1c;
  logic [63:0] rise, fall;
  logic [31:0] rdata, offset, byte_mask;
  logic [N_IRQ-1:0] irq_n;
  logic hit, acc, wr;

  assign hit       = wb_cyc_i & wb_strobe_i & (wb_addr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
  assign acc       = hit & ~wb_ack_o;
  assign wr        = acc & wb_we_i;
  assign offset    = 32'(wb_addr_i[ADDR_W-1:0]);
  assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign rise      = s2 & ~prev;
  assign fall      = ~s2 & prev;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask_v);
    return (old_v & ~mask_v) | (new_v & mask_v);
  endfunction

  always_comb begin
    out_n     = out_r;
    oeb_n     = oeb_r;
    rise_en_n = rise_en_r;
    fall_en_n = fall_en_r;
    w1c       = '0;
    rdata     = '0;
    case (offset)
      32'h00: begin
        rdata = out_r[31:0];
        if (wr) out_n[31:0] = merge(out_r[31:0], wb_data_i, byte_mask);
      end
      32'h04: begin
        rdata = out_r[63:32];
        if (wr) out_n[63:32] = merge(out_r[63:32], wb_data_i, byte_mask);
      end
      32'h08: begin
        rdata = oeb_r[31:0];
        if (wr) oeb_n[31:0] = merge(oeb_r[31:0], wb_data_i, byte_mask);
      end
      32'h0C: begin
        rdata = oeb_r[63:32];
        if (wr) oeb_n[63:32] = merge(oeb_r[63:32], wb_data_i, byte_mask);
      end
      32'h10: rdata = s2[31:0];
      32'h14: rdata = s2[63:32];
      32'h18: begin
        rdata = rise_en_r[31:0];
        if (wr) rise_en_n[31:0] = merge(rise_en_r[31:0], wb_data_i, byte_mask);
      end
      32'h1C: begin
        rdata = rise_en_r[63:32];
        if (wr) rise_en_n[63:32] = merge(rise_en_r[63:32], wb_data_i, byte_mask);
      end
      32'h20: begin
        rdata = fall_en_r[31:0];
        if (wr) fall_en_n[31:0] = merge(fall_en_r[31:0], wb_data_i, byte_mask);
      end
      32'h24: begin
        rdata = fall_en_r[63:32];
        if (wr) fall_en_n[63:32] = merge(fall_en_r[63:32], wb_data_i, byte_mask);
      end
      32'h28: begin
        rdata = stat_r[31:0];
        if (wr) w1c[31:0] = wb_data_i & byte_mask;
      end
      32'h2C: begin
        rdata = stat_r[63:32];
        if (wr) w1c[63:32] = wb_data_i & byte_mask;
      end
      32'h30: rdata = ID_VALUE;
      default: ;
    endcase
    // New edges are OR-ed in after the clear so a coincident event keeps the bit set.
    stat_n = ((stat_r & ~w1c) | (rise & rise_en_r) | (fall & fall_en_r)) & PIN_MASK;
  end

  always_comb begin
    irq_n = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      for (int unsigned p = 0; p < N_IO; p++) begin
        if ((p % N_IRQ) == k) irq_n[k] = irq_n[k] | stat_r[p];
      end
    end
  end

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      out_r     <= '0;
      oeb_r     <= PIN_MASK;
      rise_en_r <= '0;
      fall_en_r <= '0;
      stat_r    <= '0;
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
      irq       <= '0;
    end else begin
      out_r     <= out_n & PIN_MASK;
      oeb_r     <= oeb_n & PIN_MASK;
      rise_en_r <= rise_en_n & PIN_MASK;
      fall_en_r <= fall_en_n & PIN_MASK;
      stat_r    <= stat_n;
      s1        <= 64'(io_in);
      s2        <= s1;
      prev      <= s2;
      wb_ack_o  <= acc;
      wb_data_o <= acc ? rdata : '0;
      irq       <= irq_n;
    end
  end

  assign io_out = out_r[N_IO-1:0];
  assign io_oeb = oeb_r[N_IO-1:0];

endmodule

// File: tb/tb_wb_gpio_irq_bridge.sv
// Bench for wb_gpio_irq_bridge: directed register/edge/IRQ steps followed by random traffic,
// all outputs compared every cycle against a register-array reference model.
module tb_wb_gpio_irq_bridge;
  localparam int unsigned N_IO  = 38;
  localparam int unsigned N_IRQ = 3;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] ID    = 32'h0004_F740;
  localparam logic [63:0] PIN   = (64'd1 << N_IO) - 64'd1;

  logic clk = 1'b0;
  logic rst, cyc, stb, we;
  logic [3:0] sel;
  logic [31:0] adr, wdata, rdata_o;
  logic ack_o;
  logic [N_IO-1:0] io_in, io_out, io_oeb;
  logic [N_IRQ-1:0] irq;

  int errors = 0;
  int checks = 0;

  // Model: m_reg[0..5] = OUT, OEB, (IN unused), RISE_EN, FALL_EN, STAT; hist = pad samples, oldest first.
  logic [63:0] m_reg [6];
  logic [63:0] hist [$];
  logic m_ack;
  logic [31:0] m_data;
  logic [N_IRQ-1:0] m_irq;

  always #5 clk = ~clk;

  wb_gpio_irq_bridge #(.N_IO(N_IO), .N_IRQ(N_IRQ), .BASE_ADDR(BASE), .ADDR_W(8), .ID_VALUE(ID)) dut (
    .wb_clock_i(clk), .wb_reset_i(rst), .wb_cyc_i(cyc), .wb_strobe_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(adr), .wb_data_i(wdata), .wb_data_o(rdata_o), .wb_ack_o(ack_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [63:0] v;
    if (off == 32'h30) return ID;
    if (off > 32'h2C || (off % 4) != 0) return 32'h0;
    v = ((off / 8) == 2) ? hist[1] : m_reg[off / 8];
    return 32'(v >> (32 * ((off / 4) % 2)));
  endfunction

  task automatic model_step(input logic [63:0] smp);
    logic hit, acc;
    logic [31:0] off, bm, rd;
    logic [63:0] wd64, bm64, w1c, rise, fall, nstat;
    logic [N_IRQ-1:0] nirq;
    int r;
    if (rst) begin
      m_reg[0] = '0; m_reg[1] = PIN; m_reg[2] = '0; m_reg[3] = '0; m_reg[4] = '0; m_reg[5] = '0;
      hist = '{64'd0, 64'd0, 64'd0};
      m_ack = 1'b0; m_data = '0; m_irq = '0;
      return;
    end
    hit = cyc && stb && (adr >= BASE) && (adr - BASE < 32'd256);
    acc = hit && !m_ack;
    off = adr - BASE;
    bm  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    nirq = '0;
    for (int p = 0; p < int'(N_IO); p++) if (m_reg[5][p]) nirq[p % N_IRQ] = 1'b1;
    rd = acc ? model_read(off) : 32'h0;
    rise = hist[1] & ~hist[0];
    fall = ~hist[1] & hist[0];
    w1c = '0;
    r = int'(off / 8);
    wd64 = 64'(wdata) << (32 * ((off / 4) % 2));
    bm64 = 64'(bm) << (32 * ((off / 4) % 2));
    if (acc && we && off < 32'h30 && (off % 4) == 0 && r == 5) w1c = wd64 & bm64;
    nstat = ((m_reg[5] & ~w1c) | (rise & m_reg[3]) | (fall & m_reg[4])) & PIN;
    if (acc && we && off < 32'h30 && (off % 4) == 0 && r != 2 && r != 5)
      m_reg[r] = ((m_reg[r] & ~bm64) | (wd64 & bm64)) & PIN;
    m_reg[5] = nstat;
    void'(hist.pop_front());
    hist.push_back(smp);
    m_ack = acc; m_data = rd; m_irq = nirq;
  endtask

  task automatic tick();
    logic [63:0] smp;
    smp = 64'(io_in);
    @(posedge clk);
    model_step(smp);
    #1;
    chk("ack", 64'(ack_o), 64'(m_ack));
    chk("rdata", 64'(rdata_o), 64'(m_data));
    chk("io_out", 64'(io_out), m_reg[0]);
    chk("io_oeb", 64'(io_oeb), m_reg[1]);
    chk("irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic acked);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdata = d; sel = s;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      tick();
      if (ack_o) begin acked = 1'b1; rd = rdata_o; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; logic acked;
    bus(BASE + off, 1'b1, d, s, rd, acked);
    chk("write_ack", 64'(acked), 64'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd; logic acked;
    bus(BASE + off, 1'b0, 32'h0, 4'hF, rd, acked);
    chk({tag, "_ack"}, 64'(acked), 64'd1);
    chk(tag, 64'(rd), 64'(exp));
  endtask

  initial begin
    logic [31:0] rd, off, a;
    logic acked, w;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdata = '0; io_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("reset_out", 64'(io_out), 64'h0);
    chk("reset_irq", 64'(irq), 64'h0);
    rd_chk("oeb0_reset", 32'h08, 32'hFFFF_FFFF);
    rd_chk("id", 32'h30, 32'h0004_F740);

    wr(32'h00, 32'hA5A5_A5A5, 4'b0011);
    chk("io_out_lo", 64'(io_out[15:0]), 64'hA5A5);
    rd_chk("out0", 32'h00, 32'h0000_A5A5);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    rd_chk("out1", 32'h04, 32'h0000_003F);

    wr(32'h18, 32'h1, 4'hF);
    io_in[0] = 1'b1;
    tick(); tick(); tick();
    chk("irq_before", 64'(irq[0]), 64'd0);
    tick();
    chk("irq_rise", 64'(irq[0]), 64'd1);
    rd_chk("stat0_set", 32'h28, 32'h1);
    wr(32'h28, 32'h1, 4'hF);
    tick();
    chk("irq_clear", 64'(irq[0]), 64'd0);
    rd_chk("stat0_clr", 32'h28, 32'h0);

    wr(32'h24, 32'h2, 4'hF);
    io_in[33] = 1'b1;
    repeat (4) tick();
    io_in[33] = 1'b0;
    repeat (4) tick();
    rd_chk("stat1_fall", 32'h2C, 32'h2);
    chk("irq_pin33", 64'(irq[0]), 64'd1);
    wr(32'h2C, 32'h2, 4'hF);
    rd_chk("stat1_clr", 32'h2C, 32'h0);
    io_in[33] = 1'b1;
    repeat (4) tick();
    io_in[33] = 1'b0;
    tick(); tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h2C; wdata = 32'h2; sel = 4'hF;
    tick();
    chk("coinc_ack", 64'(ack_o), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    rd_chk("stat1_setwins", 32'h2C, 32'h2);

    bus(BASE + 32'h100, 1'b1, 32'h0, 4'hF, rd, acked);
    chk("outside_noack", 64'(acked), 64'd0);
    rd_chk("out0_unchanged", 32'h00, 32'h0000_A5A5);
    rd_chk("hole", 32'h40, 32'h0);

    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdata = 32'hFFFF_FFFF; sel = 4'hF; rst = 1'b1;
    tick();
    chk("rst_noack", 64'(ack_o), 64'd0);
    chk("rst_out", 64'(io_out), 64'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    tick();
    rd_chk("out0_after_rst", 32'h00, 32'h0);

    for (int it = 0; it < 400; it++) begin
      io_in = io_in ^ N_IO'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      off = ($urandom_range(0, 9) == 0) ? 32'h40 : 32'($urandom_range(0, 13)) * 4;
      a = ($urandom_range(0, 15) == 0) ? BASE + 32'h100 + off : BASE + off;
      w = 1'($urandom);
      bus(a, w, $urandom, 4'($urandom), rd, acked);
      chk("rand_ack", 64'(acked), 64'(a < BASE + 32'h100));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
